// File: rtl/seq_normalizer.sv
// Leading-zero normalizer (NORM_DIR_EN adds shift_left for trailing-zero/right mode); latency k+1 edges after accept, zero word 1 edge.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module seq_normalizer #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [AW-1:0]    shift_amount,
  output logic             zero
`ifdef NORM_DIR_EN
  ,
  input  logic             shift_left
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [AW-1:0]    r_cnt;
  logic             w_left;
  logic             w_hit;
  logic [WIDTH-1:0] w_next_word;

`ifdef NORM_DIR_EN
  logic r_left;
  assign w_left = r_left;
`else
  assign w_left = 1'b1;
`endif

  // Working register is separate so data_out keeps the previous result while shifting.
  assign w_hit       = w_left ? r_word[WIDTH-1] : r_word[0];
  assign w_next_word = w_left ? {r_word[WIDTH-2:0], 1'b0} : {1'b0, r_word[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      data_out     <= '0;
      shift_amount <= '0;
      zero         <= 1'b0;
      r_word       <= '0;
      r_cnt        <= '0;
`ifdef NORM_DIR_EN
      r_left       <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word   <= data_in;
            r_cnt    <= '0;
            in_ready <= 1'b0;
`ifdef NORM_DIR_EN
            r_left   <= shift_left;
`endif
            if (data_in == '0) begin
              data_out     <= '0;
              shift_amount <= '0;
              zero         <= 1'b1;
              out_valid    <= 1'b1;
              r_state      <= DONE;
            end else begin
              zero    <= 1'b0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // A nonzero word reaches the test bit within WIDTH-1 shifts, so r_cnt cannot wrap.
          if (w_hit) begin
            data_out     <= r_word;
            shift_amount <= r_cnt;
            out_valid    <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_word <= w_next_word;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: driver pushes expected results, a negedge monitor pops and compares.
module tb_seq_normalizer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] data_out;
  logic [2:0] shift_amount;
  logic       zero;
  logic       shift_left_s = 1'b1;

  seq_normalizer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .shift_amount(shift_amount), .zero(zero)
`ifdef NORM_DIR_EN
    , .shift_left(shift_left_s)
`endif
  );

  always #5 clk = ~clk;

  // Latency is counted in rising edges including the accept edge.
  typedef struct {
    logic [7:0] d;
    logic [2:0] sa;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   seen = 1'b0;
  bit   chk_idle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_idle) begin
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk_idle = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            chk("data_out", {24'd0, data_out}, {24'd0, exp_q[0].d});
            chk("shift_amount", {29'd0, shift_amount}, {29'd0, exp_q[0].sa});
            chk("zero", {31'd0, zero}, {31'd0, exp_q[0].z});
            chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            seen = 1'b1;
          end else if (!out_ready) begin
            chk("stall_data_out", {24'd0, data_out}, {24'd0, exp_q[0].d});
            chk("stall_shift_amount", {29'd0, shift_amount}, {29'd0, exp_q[0].sa});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic left, input logic [7:0] ed,
                      input logic [2:0] esa, input logic ez, input int elat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
      return;
    end
    in_valid = 1'b1;
    data_in = w;
    shift_left_s = left;
    e.d = ed; e.sa = esa; e.z = ez; e.lat = elat; e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in = ~w;          // junk while busy must not matter
    shift_left_s = ~left;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_shift_amount", {29'd0, shift_amount}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);

    //    word   left expected      sa    z    latency
    send(8'h1B, 1'b1, 8'hD8, 3'd3, 1'b0, 5);
    send(8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1);
    send(8'h01, 1'b1, 8'h80, 3'd7, 1'b0, 9);
    send(8'h80, 1'b1, 8'h80, 3'd0, 1'b0, 2);
    send(8'h40, 1'b1, 8'h80, 3'd1, 1'b0, 3);
    send(8'hFF, 1'b1, 8'hFF, 3'd0, 1'b0, 2);
    send(8'h0F, 1'b1, 8'hF0, 3'd4, 1'b0, 6);
    drain();

    // Hold the 0xD8/3 result for several cycles with out_ready low.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h1B, 1'b1, 8'hD8, 3'd3, 1'b0, 5);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_reached_done", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset in the middle of shifting 0x01 discards the word.
    send(8'h01, 1'b1, 8'h80, 3'd7, 1'b0, 9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    chk("mid_rst_shift_amount", {29'd0, shift_amount}, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd0);
    repeat (12) @(negedge clk);

    send(8'h02, 1'b1, 8'h80, 3'd6, 1'b0, 8);
`ifdef NORM_DIR_EN
    send(8'hD8, 1'b0, 8'h1B, 3'd3, 1'b0, 5);
    send(8'h01, 1'b0, 8'h01, 3'd0, 1'b0, 2);
`endif
    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
